// File: rtl/uart_rx_peripheral.sv
// UART receiver for the SoC memory-mapped RX path: 8N1 deserialiser with ready flag and sticky errors.
// Define UART_RX_PARITY_EN to receive 8E1 frames and expose parity_err.
module uart_rx_peripheral #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        rx_clear,
    output logic [31:0] rx_data,
    output logic        rx_flag,
    output logic        frame_err,
    output logic        overrun,
`ifdef UART_RX_PARITY_EN
    output logic        parity_err,
`endif
    output logic        busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state, next_state;
    logic            rx_meta, rx_s, rx_prev;
    logic [CW-1:0]   baud_cnt, baud_next;
    logic [2:0]      bit_cnt, bit_next;
    logic [7:0]      shift_q, data_q;
    logic            start_edge, shift_en, stop_sample, stop_good, stop_bad;

    assign start_edge = rx_prev & ~rx_s;
    assign stop_good  = stop_sample & rx_s;
    assign stop_bad   = stop_sample & ~rx_s;
    assign rx_data    = {24'h0, data_q};
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
        end else begin
            state    <= next_state;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            if (shift_en)
                shift_q <= {rx_s, shift_q[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_sample;
`endif

    always_comb begin
        next_state  = state;
        baud_next   = baud_cnt + 1'b1;
        bit_next    = bit_cnt;
        shift_en    = 1'b0;
        stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_sample  = 1'b0;
`endif
        case (state)
            IDLE: begin
                baud_next = '0;
                // The edge cycle itself is tick 0 of the start bit, so the
                // start sample lands CLKS_PER_BIT/2-1 cycles after it.
                if (start_edge) begin
                    next_state = START;
                    baud_next  = CW'(1);
                end
            end
            START: begin
                if (baud_cnt == HALF_M1) begin
                    baud_next = '0;
                    bit_next  = '0;
                    next_state = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_cnt == BIT_M1) begin
                    shift_en  = 1'b1;
                    baud_next = '0;
                    bit_next  = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7)
`ifdef UART_RX_PARITY_EN
                        next_state = PARITY;
`else
                        next_state = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (baud_cnt == BIT_M1) begin
                    par_sample = 1'b1;
                    baud_next  = '0;
                    next_state = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_cnt == BIT_M1) begin
                    stop_sample = 1'b1;
                    next_state  = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Status bits: a good stop sample outranks a coincident rx_clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q    <= '0;
            rx_flag   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (stop_good)
                data_q <= shift_q;
            rx_flag   <= stop_good | (rx_flag & ~rx_clear);
            overrun   <= (stop_good & rx_flag & ~rx_clear) | (overrun & ~rx_clear);
            frame_err <= stop_bad | (frame_err & ~rx_clear);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            parity_err <= 1'b0;
        else
            parity_err <= (par_sample & (^{shift_q, rx_s})) | (parity_err & ~rx_clear);
    end
`endif
endmodule

// File: tb/tb_uart_rx_peripheral.sv
// Randomised self-checking bench for uart_rx_peripheral against a frame-level reference model.
// Honours UART_RX_PARITY_EN for 8E1 frames.
module tb_uart_rx_peripheral;
    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // Pad falls at cycle 0; 2 sync cycles, then mid-point of the stop bit.
    localparam int STOP_I = 2 + (NB - 1) * CPB + CPB / 2 - 1;

    logic        clk = 1'b0;
    logic        rst, rx, rx_clear;
    logic [31:0] rx_data;
    logic        rx_flag, frame_err, overrun, busy, perr_w;

    uart_rx_peripheral #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_clear(rx_clear),
        .rx_data(rx_data), .rx_flag(rx_flag), .frame_err(frame_err),
        .overrun(overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err(perr_w),
`endif
        .busy(busy)
    );
`ifndef UART_RX_PARITY_EN
    assign perr_w = 1'b0;
`endif

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [7:0] m_data;
    logic       m_flag, m_ferr, m_ovr, m_perr;
    logic       obs_pre, obs_post;

    logic [36:0] obs;
    assign obs = {rx_data, rx_flag, frame_err, overrun, busy, perr_w};

    function automatic logic [36:0] expv();
        return {24'h0, m_data, m_flag, m_ferr, m_ovr, 1'b0, m_perr};
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        m_data = 8'h0; m_flag = 0; m_ferr = 0; m_ovr = 0; m_perr = 0;
    endtask

    // Reference rules for one complete frame; clr marks rx_clear landing on the stop sample.
    task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok, input bit clr);
        if (!par_ok) m_perr = 1;
        if (clr) m_perr = 0;
        m_ferr = (m_ferr && !clr) || !stop_ok;
        m_ovr  = (m_ovr && !clr) || (stop_ok && m_flag && !clr);
        m_flag = stop_ok || (m_flag && !clr);
        if (stop_ok) m_data = b;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok, input bit clr);
        logic [NB-1:0] fr;
        fr = '0;
        fr[8:1] = b;
`ifdef UART_RX_PARITY_EN
        fr[9] = (^b) ^ !par_ok;
`endif
        fr[NB-1] = stop_ok;
        for (int i = 0; i < NB * CPB; i++) begin
            rx = fr[i / CPB];
            rx_clear = clr && (i == STOP_I);
            if (i == STOP_I) obs_pre = rx_flag;
            if (i == STOP_I + 1) obs_post = rx_flag;
            tick(1);
        end
        rx = 1'b1;
        rx_clear = 1'b0;
        tick(4);
        model_frame(b, stop_ok, par_ok, clr);
    endtask

    task automatic pulse_clear();
        rx_clear = 1'b1;
        tick(1);
        rx_clear = 1'b0;
        m_flag = 0; m_ferr = 0; m_ovr = 0; m_perr = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; rx_clear = 1'b0;
        model_reset();
        tick(3);
        total++;
        if (obs !== expv()) begin bad++; $display("FAIL reset: got %h want %h", obs, expv()); end
        rst = 1'b0;
        tick(3);
    endtask

    task automatic test_basic();
        logic prev;
        prev = m_flag;
        send_frame(8'h55, 1, 1, 0);
        total++;
        if (obs_pre !== prev || obs_post !== 1'b1) begin
            bad++; $display("FAIL basic_latency: got pre=%b post=%b want pre=%b post=1", obs_pre, obs_post, prev);
        end
        total++;
        if (obs !== expv()) begin bad++; $display("FAIL basic_0x55: got %h want %h", obs, expv()); end
    endtask

    task automatic test_glitch();
        pulse_clear();
        for (int i = 0; i < 4; i++) begin
            rx = 1'b0;
            tick(1);
        end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy: got %b want 1", busy); end
        rx = 1'b1;
        tick(20);
        total++;
        if (obs !== expv()) begin bad++; $display("FAIL glitch_idle: got %h want %h", obs, expv()); end
    endtask

    task automatic test_frame_err();
        send_frame(8'hA3, 0, 1, 0);
        total++;
        if (obs !== expv() || obs_post !== 1'b0) begin
            bad++; $display("FAIL frame_err_a3: got %h post=%b want %h post=0", obs, obs_post, expv());
        end
        send_frame(8'h3C, 1, 1, 0);
        total++;
        if (obs !== expv()) begin bad++; $display("FAIL frame_err_then_3c: got %h want %h", obs, expv()); end
    endtask

    task automatic test_overrun();
        pulse_clear();
        send_frame(8'h12, 1, 1, 0);
        send_frame(8'h34, 1, 1, 0);
        total++;
        if (obs !== expv()) begin bad++; $display("FAIL overrun_34: got %h want %h", obs, expv()); end
        pulse_clear();
        total++;
        if (obs !== expv()) begin bad++; $display("FAIL overrun_clear: got %h want %h", obs, expv()); end
    endtask

    task automatic test_clear_at_stop();
        send_frame(8'h9E, 1, 1, 0);
        send_frame(8'h6B, 1, 1, 1);
        total++;
        if (obs !== expv() || obs_post !== 1'b1) begin
            bad++; $display("FAIL clear_at_stop: got %h post=%b want %h post=1", obs, obs_post, expv());
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] fr;
        send_frame(8'h5A, 1, 1, 0);
        fr = {1'b1, 8'hF0, 1'b0};
        for (int i = 0; i < 5 * CPB + CPB / 2; i++) begin
            rx = fr[i / CPB];
            tick(1);
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        total++;
        if (obs !== expv()) begin bad++; $display("FAIL reset_mid: got %h want %h", obs, expv()); end
        rx = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(4);
        send_frame(8'h81, 1, 1, 0);
        total++;
        if (obs !== expv()) begin bad++; $display("FAIL reset_then_81: got %h want %h", obs, expv()); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        pulse_clear();
        send_frame(8'h07, 1, 1, 0);
        total++;
        if (obs !== expv() || perr_w !== 1'b0) begin bad++; $display("FAIL parity_ok: got %h want %h", obs, expv()); end
        send_frame(8'h07, 1, 0, 0);
        total++;
        if (obs !== expv() || perr_w !== 1'b1) begin bad++; $display("FAIL parity_bad: got %h want %h", obs, expv()); end
    endtask
`endif

    task automatic test_random();
        logic [7:0] b;
        bit sok, pok, clr;
        logic want_post;
        for (int n = 0; n < 30; n++) begin
            b   = 8'($urandom_range(0, 255));
            sok = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
            pok = ($urandom_range(0, 3) != 0);
`else
            pok = 1;
`endif
            clr = sok && ($urandom_range(0, 3) == 0);
            want_post = sok || (m_flag && !clr);
            send_frame(b, sok, pok, clr);
            total++;
            if (obs_post !== want_post) begin
                bad++; $display("FAIL rand_latency[%0d]: got %b want %b", n, obs_post, want_post);
            end
            total++;
            if (obs !== expv()) begin bad++; $display("FAIL rand_frame[%0d]: got %h want %h", n, obs, expv()); end
            if ($urandom_range(0, 2) == 0) begin
                pulse_clear();
                total++;
                if (obs !== expv()) begin bad++; $display("FAIL rand_clear[%0d]: got %h want %h", n, obs, expv()); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_clear_at_stop();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
